// File: rtl/falling_letter_scheduler.sv
// Falling-letter game sequencer: spawns LFSR letters, drops them on a tick, scores hits and misses.
// Optional SPEEDUP_EN: the drop period halves every 8 points, floored at DROP_DIV>>3 (min 1).
module falling_letter_scheduler #(
    parameter int unsigned DROP_DIV   = 25000000,
    parameter int unsigned SPAWN_ROWS = 8,
    parameter int unsigned MAX_MISSES = 3,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       guess_valid,
    input  logic [7:0] guess,
    output logic [7:0] letter1,
    output logic [7:0] letter2,
    output logic [7:0] letter3,
    output logic [4:0] ypos1,
    output logic [4:0] ypos2,
    output logic [4:0] ypos3,
    output logic [7:0] score,
    output logic [3:0] misses,
    output logic       game_over
);
    localparam int unsigned DW = $clog2(DROP_DIV);
    localparam int unsigned SW = (SPAWN_ROWS > 1) ? $clog2(SPAWN_ROWS) : 1;
    localparam logic [DW:0]   P_FULL  = (DW+1)'(DROP_DIV);
    localparam logic [SW-1:0] S_LAST  = SW'(SPAWN_ROWS - 1);
    localparam logic [3:0]    M_LIM   = 4'(MAX_MISSES);
    localparam logic [4:0]    Y_EMPTY = 5'd31;
    localparam logic [4:0]    Y_LAST  = 5'd21;
`ifdef SPEEDUP_EN
    localparam int unsigned   P_MIN_I = ((DROP_DIV >> 3) > 0) ? (DROP_DIV >> 3) : 1;
    localparam logic [DW:0]   P_MIN   = (DW+1)'(P_MIN_I);
`endif

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t          r_state, w_state;
    logic [7:0]      r_lfsr, w_lfsr;
    logic [DW-1:0]   r_div, w_div;
    logic [SW-1:0]   r_spawn, w_spawn;
    logic [2:0][4:0] r_ypos, w_ypos;
    logic [2:0][7:0] r_letter, w_letter;
    logic [7:0]      r_score, w_score;
    logic [3:0]      r_misses, w_misses;
    logic            r_game_over, w_game_over;
    logic [DW:0]     w_period;
`ifdef SPEEDUP_EN
    logic [DW:0]     r_period, w_period_nxt;
    assign w_period = r_period;
`else
    assign w_period = P_FULL;
`endif

    logic [4:0] w_r;
    logic [7:0] w_new_letter;
    logic       w_step, w_hit, w_spawned;
    logic [1:0] w_hit_idx, w_retires;
    logic [4:0] w_hit_y, w_miss_sum;

    assign w_r          = r_lfsr[4:0];
    assign w_new_letter = 8'h41 + {3'b000, (w_r >= 5'd26) ? (w_r - 5'd26) : w_r};
    // >= rather than == so a period that just shrank below the count still ticks
    assign w_step       = ({1'b0, r_div} >= (w_period - (DW+1)'(1)));

    // Deepest matching slot wins; strict > keeps the lowest index on a tie.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = 2'd0;
        w_hit_y   = 5'd0;
        for (int i = 0; i < 3; i++) begin
            if (guess_valid && (r_ypos[i] != Y_EMPTY) && (r_letter[i] == guess) &&
                (!w_hit || (r_ypos[i] > w_hit_y))) begin
                w_hit     = 1'b1;
                w_hit_idx = 2'(i);
                w_hit_y   = r_ypos[i];
            end
        end
    end

    always_comb begin
        w_state     = r_state;
        w_lfsr      = {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
        w_div       = r_div;
        w_spawn     = r_spawn;
        w_ypos      = r_ypos;
        w_letter    = r_letter;
        w_score     = r_score;
        w_misses    = r_misses;
        w_game_over = r_game_over;
        w_retires   = 2'd0;
        w_spawned   = 1'b0;
        w_miss_sum  = 5'd0;
`ifdef SPEEDUP_EN
        w_period_nxt = r_period;
`endif
        case (r_state)
            IDLE, OVER: begin
                if (start) begin
                    w_state     = RUN;
                    w_game_over = 1'b0;
                    w_score     = 8'd0;
                    w_misses    = 4'd0;
                    w_ypos      = {3{Y_EMPTY}};
                    w_div       = '0;
                    w_spawn     = S_LAST;
`ifdef SPEEDUP_EN
                    w_period_nxt = P_FULL;
`endif
                end
            end
            RUN: begin
                if (r_misses >= M_LIM) begin
                    w_state     = OVER;
                    w_game_over = 1'b1;
                end else begin
                    w_div = w_step ? '0 : (r_div + DW'(1));
                    if (w_hit) begin
                        w_ypos[w_hit_idx] = Y_EMPTY;
                        if (r_score != 8'hFF) begin
                            w_score = r_score + 8'd1;
`ifdef SPEEDUP_EN
                            if (w_score[2:0] == 3'd0)
                                w_period_nxt = ((r_period >> 1) < P_MIN) ? P_MIN : (r_period >> 1);
`endif
                        end
                    end
                    if (w_step) begin
                        // The hit slot is already cleared and must not step or retire.
                        for (int i = 0; i < 3; i++) begin
                            if (!(w_hit && (w_hit_idx == 2'(i))) && (r_ypos[i] != Y_EMPTY)) begin
                                if (r_ypos[i] < Y_LAST) begin
                                    w_ypos[i] = r_ypos[i] + 5'd1;
                                end else begin
                                    w_ypos[i] = Y_EMPTY;
                                    w_retires = w_retires + 2'd1;
                                end
                            end
                        end
                        w_miss_sum = {1'b0, r_misses} + {3'b000, w_retires};
                        w_misses   = (w_miss_sum > 5'd15) ? 4'hF : w_miss_sum[3:0];
                        if (r_spawn == S_LAST) begin
                            for (int i = 0; i < 3; i++) begin
                                if (!w_spawned && (w_ypos[i] == Y_EMPTY)) begin
                                    w_ypos[i]   = 5'd0;
                                    w_letter[i] = w_new_letter;
                                    w_spawned   = 1'b1;
                                end
                            end
                            if (w_spawned) w_spawn = '0;
                        end else begin
                            w_spawn = r_spawn + SW'(1);
                        end
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_lfsr      <= LFSR_SEED;
            r_div       <= '0;
            r_spawn     <= '0;
            r_ypos      <= {3{Y_EMPTY}};
            r_letter    <= '0;
            r_score     <= 8'd0;
            r_misses    <= 4'd0;
            r_game_over <= 1'b0;
`ifdef SPEEDUP_EN
            r_period    <= P_FULL;
`endif
        end else begin
            r_state     <= w_state;
            r_lfsr      <= w_lfsr;
            r_div       <= w_div;
            r_spawn     <= w_spawn;
            r_ypos      <= w_ypos;
            r_letter    <= w_letter;
            r_score     <= w_score;
            r_misses    <= w_misses;
            r_game_over <= w_game_over;
`ifdef SPEEDUP_EN
            r_period    <= w_period_nxt;
`endif
        end
    end

    assign letter1   = r_letter[0];
    assign letter2   = r_letter[1];
    assign letter3   = r_letter[2];
    assign ypos1     = r_ypos[0];
    assign ypos2     = r_ypos[1];
    assign ypos3     = r_ypos[2];
    assign score     = r_score;
    assign misses    = r_misses;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_falling_letter_scheduler.sv
// Directed bench for falling_letter_scheduler: a cycle-timed vector table for one full game,
// then hand-written sequences for async reset and drop-period measurement.
module tb_falling_letter_scheduler;
    localparam int DROP_DIV   = 4;
    localparam int SPAWN_ROWS = 2;
    localparam int MAX_MISSES = 3;
`ifdef SPEEDUP_EN
    localparam int EXP_P8  = 2;
    localparam int EXP_P24 = 1;
`else
    localparam int EXP_P8  = 4;
    localparam int EXP_P24 = 4;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       guess_valid = 1'b0;
    logic [7:0] guess = 8'h00;
    logic [7:0] letter1, letter2, letter3, score;
    logic [4:0] ypos1, ypos2, ypos3;
    logic [3:0] misses;
    logic       game_over;

    int n_err = 0;
    int n_chk = 0;

    falling_letter_scheduler #(
        .DROP_DIV(DROP_DIV), .SPAWN_ROWS(SPAWN_ROWS), .MAX_MISSES(MAX_MISSES), .LFSR_SEED(8'hA5)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .guess_valid(guess_valid), .guess(guess),
        .letter1(letter1), .letter2(letter2), .letter3(letter3),
        .ypos1(ypos1), .ypos2(ypos2), .ypos3(ypos3),
        .score(score), .misses(misses), .game_over(game_over)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // gsel: 0 none, 1..3 guess that slot's letter, 4 guess a non-letter.
    // n: edges to advance; inputs are applied on the last of them.
    typedef struct {
        bit st;
        int gsel;
        int n;
        int y1, y2, y3, sc, ms, go;
    } vec_t;
    vec_t vt[$];

    task automatic add(input bit st, input int gsel, input int n, input int y1, input int y2,
                       input int y3, input int sc, input int ms, input int go);
        vec_t v;
        v.st = st; v.gsel = gsel; v.n = n;
        v.y1 = y1; v.y2 = y2; v.y3 = y3; v.sc = sc; v.ms = ms; v.go = go;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    function automatic int yp(input int k);
        return (k == 0) ? int'(ypos1) : (k == 1) ? int'(ypos2) : int'(ypos3);
    endfunction

    function automatic logic [7:0] lt(input int k);
        return (k == 0) ? letter1 : (k == 1) ? letter2 : letter3;
    endfunction

    task automatic wait_active(output int k);
        int t;
        t = 0;
        k = -1;
        while (k < 0 && t < 200) begin
            for (int i = 0; i < 3; i++) if (k < 0 && yp(i) != 31) k = i;
            if (k < 0) begin
                @(negedge clock);
                t++;
            end
        end
        if (k < 0) begin
            chk("wait_active_timeout", 0, 1);
            k = 0;
        end
    endtask

    task automatic do_hit();
        int k;
        wait_active(k);
        guess = lt(k);
        guess_valid = 1'b1;
        @(posedge clock);
        #1 guess_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic measure_period(output int c);
        int k, prev, t;
        wait_active(k);
        prev = yp(k);
        t = 0;
        while (yp(k) == prev && t < 50) begin @(negedge clock); t++; end
        prev = yp(k);
        c = 0;
        while (yp(k) == prev && c < 50) begin @(negedge clock); c++; end
    endtask

    initial begin
        int per;
        int k;
        // Steps land on edges 4,8,12,... after the start edge; spawns every 2nd step.
        // A slot freed by a retire or hit on a spawn step is refilled in that same step.
        add(1, 0,  1, 31, 31, 31, 0, 0, 0);
        add(0, 0,  3, 31, 31, 31, 0, 0, 0);
        add(0, 0,  1,  0, 31, 31, 0, 0, 0);
        add(0, 0,  4,  1, 31, 31, 0, 0, 0);
        add(0, 0,  4,  2,  0, 31, 0, 0, 0);
        add(0, 0,  8,  4,  2,  0, 0, 0, 0);
        add(0, 0, 68, 21, 19, 17, 0, 0, 0);
        add(0, 0,  4,  0, 20, 18, 0, 1, 0);
        add(0, 0,  4,  1, 21, 19, 0, 1, 0);
        add(0, 2,  4,  2,  0, 20, 1, 1, 0);
        add(0, 0,  4,  3,  1, 21, 1, 1, 0);
        add(0, 0,  4,  4,  2,  0, 1, 2, 0);
        add(0, 0,  4,  5,  3,  1, 1, 2, 0);
        add(0, 1,  1, 31,  3,  1, 2, 2, 0);
        add(0, 4,  1, 31,  3,  1, 2, 2, 0);
        add(0, 0,  2,  0,  4,  2, 2, 2, 0);
        add(0, 0, 72, 18,  0, 20, 2, 3, 0);
        add(0, 0,  1, 18,  0, 20, 2, 3, 1);
        add(0, 1, 20, 18,  0, 20, 2, 3, 1);
        add(1, 0,  1, 31, 31, 31, 0, 0, 0);

        repeat (2) @(negedge clock);
        chk("rst_ypos1", ypos1, 31);
        chk("rst_ypos2", ypos2, 31);
        chk("rst_ypos3", ypos3, 31);
        chk("rst_letter1", letter1, 0);
        chk("rst_score", score, 0);
        chk("rst_misses", misses, 0);
        chk("rst_game_over", game_over, 0);
        reset_n = 1'b1;
        @(negedge clock);

        foreach (vt[i]) begin
            repeat (vt[i].n - 1) @(negedge clock);
            start = vt[i].st;
            guess_valid = (vt[i].gsel != 0);
            case (vt[i].gsel)
                1: guess = letter1;
                2: guess = letter2;
                3: guess = letter3;
                default: guess = 8'h2A;
            endcase
            @(posedge clock);
            #1 start = 1'b0;
            guess_valid = 1'b0;
            @(negedge clock);
            chk($sformatf("v%0d_ypos1", i), ypos1, vt[i].y1);
            chk($sformatf("v%0d_ypos2", i), ypos2, vt[i].y2);
            chk($sformatf("v%0d_ypos3", i), ypos3, vt[i].y3);
            chk($sformatf("v%0d_score", i), score, vt[i].sc);
            chk($sformatf("v%0d_misses", i), misses, vt[i].ms);
            chk($sformatf("v%0d_game_over", i), game_over, vt[i].go);
            if (vt[i].y1 != 31)
                chk($sformatf("v%0d_letter1_range", i),
                    int'(letter1 >= 8'h41 && letter1 <= 8'h5A), 1);
        end

        // Async reset mid-game with a non-zero score.
        do_hit();
        chk("restart_hit_score", score, 1);
        wait_active(k);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_ypos1", ypos1, 31);
        chk("async_rst_ypos2", ypos2, 31);
        chk("async_rst_ypos3", ypos3, 31);
        chk("async_rst_score", score, 0);
        chk("async_rst_game_over", game_over, 0);
        chk("async_rst_letter1", letter1, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);

        // Drop period after 8 and 24 hits.
        repeat (8) do_hit();
        chk("score_after_8", score, 8);
        measure_period(per);
        chk("period_after_8", per, EXP_P8);
        repeat (16) do_hit();
        chk("score_after_24", score, 24);
        measure_period(per);
        chk("period_after_24", per, EXP_P24);
        chk("misses_speed_phase", misses, 0);
        chk("game_over_speed_phase", game_over, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
